// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: shares the SiTCP TCP TX byte port between N_SRC packet
// sources. Grants rotate round-robin per packet, an optional 0xA0|id header
// byte precedes each packet, and packets cut short by a connection close are
// drained from their source and counted in drop_count.
module tcp_tx_arbiter #(
    parameter int N_SRC  = 4,
    parameter bit HDR_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               tcp_open_ack,
    input  logic               tcp_tx_full,
    output logic               tcp_tx_wr,
    output logic [7:0]         tcp_tx_data,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_last,
    output logic [N_SRC-1:0]   src_ready,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic [15:0]        drop_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    logic [1:0]             state;
    logic [2:0]             rr_ptr;     // last granted source; search starts one above
    logic [N_SRC-1:0][7:0]  src_bytes;
    logic                   sel_valid;
    logic                   sel_last;
    logic [7:0]             sel_byte;
    logic [2:0]             pick;
    logic                   found;

    assign src_bytes = src_data;
    assign busy      = (state != ST_IDLE);

    // Route the granted source's handshake signals and drive its ready bit
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        src_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == 3'(i)) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_byte  = src_bytes[i];
                if (state == ST_DATA)
                    src_ready[i] = tcp_open_ack & ~tcp_tx_full;
                else if (state == ST_FLUSH)
                    src_ready[i] = 1'b1;
            end
        end
    end

    // Round-robin search: first valid source above the last grant, with wrap
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!found && (i == (int'(rr_ptr) + k) % N_SRC) && src_valid[i]) begin
                    pick  = 3'(i);
                    found = 1'b1;
                end
            end
        end
    end

    // Packet FSM, registered TX strobe/byte and drop counter
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= ST_IDLE;
            rr_ptr      <= 3'(N_SRC - 1);
            grant_id    <= '0;
            tcp_tx_wr   <= 1'b0;
            tcp_tx_data <= '0;
            drop_count  <= '0;
        end else begin
            tcp_tx_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Sources are held (not drained) while the link is down
                    if (tcp_open_ack && !tcp_tx_full && found) begin
                        grant_id <= pick;
                        rr_ptr   <= pick;
                        state    <= HDR_EN ? ST_HEADER : ST_DATA;
                    end
                end
                ST_HEADER: begin
                    if (!tcp_open_ack) begin
                        state <= ST_FLUSH;
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                    end else if (!tcp_tx_full) begin
                        tcp_tx_wr   <= 1'b1;
                        tcp_tx_data <= 8'hA0 | {5'b0, grant_id};
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Connection loss wins over full/last; that cycle's byte is refused
                    if (!tcp_open_ack) begin
                        state <= ST_FLUSH;
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                    end else if (sel_valid && !tcp_tx_full) begin
                        tcp_tx_wr   <= 1'b1;
                        tcp_tx_data <= sel_byte;
                        if (sel_last) state <= ST_IDLE;
                    end
                end
                default: begin
                    // FLUSH: swallow the rest of the truncated packet
                    if (sel_valid && sel_last) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Bench for tcp_tx_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked against a packet-level round-robin model.
module tb_tcp_tx_arbiter;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RSTn = 1'b0;
    logic           tcp_open_ack = 1'b0;
    logic           tcp_tx_full = 1'b0;
    logic           tcp_tx_wr;
    logic [7:0]     tcp_tx_data;
    logic [N-1:0]   src_valid;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic [2:0]     grant_id;
    logic           busy;
    logic [15:0]    drop_count;

    tcp_tx_arbiter #(.N_SRC(N), .HDR_EN(1'b1)) dut (
        .CLK(CLK), .RSTn(RSTn), .tcp_open_ack(tcp_open_ack), .tcp_tx_full(tcp_tx_full),
        .tcp_tx_wr(tcp_tx_wr), .tcp_tx_data(tcp_tx_data), .src_valid(src_valid),
        .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .grant_id(grant_id), .busy(busy), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // source-side byte queues (driver) and packet lists (model)
    logic [7:0] dq [N][$];
    bit         lq [N][$];
    bit         first_b [N];
    int         gap_pct = 0;
    logic [N-1:0] xfer = '0;
    logic [7:0] mb [N][$];
    int         ml [N][$];
    int         cur_len [N];

    logic [7:0] out_q [$];
    int         out_cyc [$];
    logic [7:0] exp_q [$];
    logic [7:0] ref_q [$];
    bit         exp_en = 1'b0;
    bit         chk_fr = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] b, input bit last);
        dq[s].push_back(b);
        lq[s].push_back(last);
        mb[s].push_back(b);
        cur_len[s]++;
        if (last) begin
            ml[s].push_back(cur_len[s]);
            cur_len[s] = 0;
        end
    endtask

    function automatic bit pend();
        for (int i = 0; i < N; i++) if (dq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected TX stream: visit sources round-robin from the reset pointer,
    // each visit sends one whole packet of the next source still holding one.
    task automatic model_build();
        int last = N - 1;
        int nxt;
        int len;
        do begin
            nxt = -1;
            for (int k = 1; k <= N; k++)
                if (nxt < 0 && ml[(last + k) % N].size() > 0) nxt = (last + k) % N;
            if (nxt >= 0) begin
                len = ml[nxt].pop_front();
                exp_q.push_back(8'hA0 | 8'(nxt));
                repeat (len) exp_q.push_back(mb[nxt].pop_front());
                last = nxt;
            end
        end while (nxt >= 0);
    endtask

    task automatic cmp_out(input string name);
        chk(out_q.size() == ref_q.size(), {name, "_len"}, out_q.size(), ref_q.size());
        for (int i = 0; i < out_q.size() && i < ref_q.size(); i++)
            chk(out_q[i] == ref_q[i], {name, "_byte"}, out_q[i], ref_q[i]);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            dq[i].delete(); lq[i].delete(); mb[i].delete(); ml[i].delete();
            first_b[i] = 1'b1;
            cur_len[i] = 0;
        end
        out_q.delete(); out_cyc.delete(); exp_q.delete();
        exp_en = 1'b0; chk_fr = 1'b0; gap_pct = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0; tcp_open_ack = 1'b0; tcp_tx_full = 1'b0;
        @(negedge CLK); #2;
        clear_bench();
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic drain(input int max, input string name);
        int n = 0;
        while ((pend() || busy) && n < max) begin
            @(negedge CLK); #2;
            n++;
        end
        chk(n < max, name, n, max);
    endtask

    // Source driver: present head-of-queue bytes, pop on handshake
    initial begin
        src_valid = '0; src_data = '0; src_last = '0;
        for (int i = 0; i < N; i++) first_b[i] = 1'b1;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (xfer[i] && dq[i].size() > 0) begin
                    first_b[i] = lq[i][0];
                    void'(dq[i].pop_front());
                    void'(lq[i].pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                if (dq[i].size() > 0 && (first_b[i] || $urandom_range(99) >= gap_pct)) begin
                    src_valid[i] = 1'b1;
                    src_data[8*i +: 8] = dq[i][0];
                    src_last[i] = lq[i][0];
                end else begin
                    src_valid[i] = 1'b0;
                    src_data[8*i +: 8] = 8'h00;
                    src_last[i] = 1'b0;
                end
            end
            #4;
            xfer = src_valid & src_ready;
        end
    end

    // Per-cycle compare process
    initial begin
        logic [7:0] last_data;
        logic [7:0] e;
        bit pv_open, pv_full;
        last_data = '0; pv_open = 1'b0; pv_full = 1'b1;
        forever begin
            @(negedge CLK); #1;
            if (!RSTn) begin
                chk({tcp_tx_wr, busy, grant_id, src_ready, tcp_tx_data} == 17'd0, "reset_vals",
                    {tcp_tx_wr, busy, grant_id, src_ready, tcp_tx_data}, 0);
                chk(drop_count == 16'd0, "reset_drop", drop_count, 0);
                last_data = '0; pv_open = 1'b0; pv_full = 1'b1;
            end else begin
                chk($countones(src_ready) <= 1, "ready_onehot", src_ready, 0);
                if (tcp_tx_wr) begin
                    chk(pv_open && !pv_full, "wr_flow", {pv_open, pv_full}, 2);
                    out_q.push_back(tcp_tx_data);
                    out_cyc.push_back(cyc);
                    last_data = tcp_tx_data;
                    if (tcp_tx_data[7:3] == 5'b10100)
                        chk(grant_id == tcp_tx_data[2:0], "hdr_grant", grant_id, tcp_tx_data[2:0]);
                    if (exp_en) begin
                        if (exp_q.size() == 0) chk(1'b0, "stream_extra", tcp_tx_data, 0);
                        else begin
                            e = exp_q.pop_front();
                            chk(tcp_tx_data == e, "stream_byte", tcp_tx_data, e);
                        end
                    end
                end else begin
                    chk(tcp_tx_data == last_data, "data_hold", tcp_tx_data, last_data);
                end
                if (chk_fr && tcp_tx_full) chk(src_ready == '0, "ready_full", src_ready, 0);
                pv_open = tcp_open_ack;
                pv_full = tcp_tx_full;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n, nfw, base, mask, total, complete, cnt, cur;
        logic [7:0] b;

        do_reset();

        // 1: single 3-byte packet from source 0
        tcp_open_ack = 1'b1;
        push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0); push_byte(0, 8'h33, 1);
        drain(200, "t1_drain");
        ref_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        cmp_out("t1");
        if (out_cyc.size() == 4) chk(out_cyc[3] - out_cyc[0] == 3, "t1_consec", out_cyc[3] - out_cyc[0], 3);
        chk(busy == 1'b0, "t1_busy", busy, 0);

        // 2: round-robin between sources 0, 1, 3
        do_reset();
        tcp_open_ack = 1'b1;
        push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1);
        push_byte(0, 8'h03, 0); push_byte(0, 8'h04, 1);
        push_byte(1, 8'h11, 0); push_byte(1, 8'h12, 1);
        push_byte(3, 8'h31, 0); push_byte(3, 8'h32, 1);
        drain(300, "t2_drain");
        ref_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
        cmp_out("t2");

        // 3: tcp_tx_full for 5 cycles mid-packet
        do_reset();
        tcp_open_ack = 1'b1;
        chk_fr = 1'b1;
        for (int k = 0; k < 10; k++) push_byte(0, 8'h40 + 8'(k), k == 9);
        n = 0;
        while (out_q.size() < 4 && n < 100) begin @(negedge CLK); #2; n++; end
        chk(n < 100, "t3_start", n, 100);
        nfw = 0;
        repeat (5) begin
            @(negedge CLK); tcp_tx_full = 1'b1;
            #2; nfw += int'(tcp_tx_wr);
        end
        @(negedge CLK); tcp_tx_full = 1'b0;
        chk(nfw <= 1, "t3_wr_after_full", nfw, 1);
        drain(200, "t3_drain");
        ref_q = '{8'hA0, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
        cmp_out("t3");

        // 4: connection drops after byte 4 of an 8-byte packet
        do_reset();
        tcp_open_ack = 1'b1;
        for (int k = 0; k < 8; k++) push_byte(0, 8'h51 + 8'(k), k == 7);
        n = 0;
        while (out_q.size() < 4 && n < 100) begin @(negedge CLK); #2; n++; end
        chk(n < 100, "t4_start", n, 100);
        @(negedge CLK); tcp_open_ack = 1'b0;
        drain(200, "t4_flush");
        ref_q = '{8'hA0, 8'h51, 8'h52, 8'h53, 8'h54};
        cmp_out("t4");
        chk(drop_count == 16'd1, "t4_drop", drop_count, 1);
        chk(busy == 1'b0, "t4_idle", busy, 0);

        // 6: async reset mid-packet (drop_count still 1 from the previous case)
        @(negedge CLK); tcp_open_ack = 1'b1;
        base = out_q.size();
        for (int k = 0; k < 8; k++) push_byte(1, 8'h61 + 8'(k), k == 7);
        n = 0;
        while (out_q.size() < base + 3 && n < 100) begin @(negedge CLK); #2; n++; end
        chk(n < 100, "t6_start", n, 100);
        chk(drop_count == 16'd1 && busy, "t6_pre", {busy, drop_count}, 17'h10001);
        @(negedge CLK); #2;
        RSTn = 1'b0;
        #1;
        chk({tcp_tx_wr, busy, grant_id, src_ready, tcp_tx_data} == 17'd0, "t6_async",
            {tcp_tx_wr, busy, grant_id, src_ready, tcp_tx_data}, 0);
        chk(drop_count == 16'd0, "t6_drop_clr", drop_count, 0);
        @(negedge CLK); #2;
        clear_bench();
        @(negedge CLK); RSTn = 1'b1;
        push_byte(2, 8'h05, 0); push_byte(2, 8'h06, 0); push_byte(2, 8'h07, 1);
        drain(200, "t6_drain");
        ref_q = '{8'hA2, 8'h05, 8'h06, 8'h07};
        cmp_out("t6");

        // 5: connection closed with all sources valid, then opened
        do_reset();
        for (int i = 0; i < N; i++) begin
            push_byte(i, 8'(16 * i + 1), 0);
            push_byte(i, 8'(16 * i + 2), 1);
        end
        repeat (20) begin
            @(negedge CLK); #2;
            chk(src_ready == '0 && !tcp_tx_wr, "t5_closed", {tcp_tx_wr, src_ready}, 0);
        end
        model_build();
        chk(exp_q.size() == 12 && exp_q[0] == 8'hA0 && exp_q[3] == 8'hA1 && exp_q[9] == 8'hA3,
            "t5_model", exp_q.size(), 12);
        exp_en = 1'b1;
        @(negedge CLK); tcp_open_ack = 1'b1;
        drain(300, "t5_drain");
        chk(exp_q.size() == 0, "t5_stream_short", exp_q.size(), 0);
        if (out_q.size() > 0) chk(out_q[0] == 8'hA0, "t5_first", out_q[0], 8'hA0);

        // Random phase A: link up, random full, mid-packet valid gaps
        repeat (3) begin
            do_reset();
            tcp_open_ack = 1'b1;
            gap_pct = 25;
            chk_fr = 1'b1;
            mask = $urandom_range(1, 15);
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    repeat ($urandom_range(2, 6)) begin
                        n = $urandom_range(1, 6);
                        for (int k = 0; k < n; k++) push_byte(i, 8'($urandom_range(0, 127)), k == n - 1);
                    end
                end
            end
            model_build();
            exp_en = 1'b1;
            n = 0;
            while ((pend() || busy) && n < 4000) begin
                @(negedge CLK); tcp_tx_full = ($urandom_range(99) < 30);
                #2; n++;
            end
            @(negedge CLK); tcp_tx_full = 1'b0;
            chk(n < 4000, "rndA_drain", n, 4000);
            chk(exp_q.size() == 0, "rndA_stream_short", exp_q.size(), 0);
        end

        // Random phase B: link toggles; drops = packets not delivered whole
        do_reset();
        tcp_open_ack = 1'b1;
        gap_pct = 20;
        total = 0;
        for (int i = 0; i < N; i++) begin
            repeat (5) begin
                for (int k = 0; k < 4; k++) push_byte(i, {1'b0, 2'(i), 5'($urandom_range(0, 31))}, k == 3);
                total++;
            end
        end
        n = 0;
        while ((pend() || busy) && n < 6000) begin
            @(negedge CLK);
            if ($urandom_range(99) < 6) tcp_open_ack = ~tcp_open_ack;
            tcp_tx_full = ($urandom_range(99) < 20);
            #2; n++;
        end
        @(negedge CLK); tcp_open_ack = 1'b1; tcp_tx_full = 1'b0;
        drain(1000, "rndB_drain");
        complete = 0; cnt = -1; cur = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            b = out_q[i];
            if (b[7:3] == 5'b10100) begin
                if (cnt == 4) complete++;
                cnt = 0; cur = int'(b[2:0]);
            end else begin
                chk(cnt >= 0 && int'(b[6:5]) == cur, "rndB_tag", b, cur);
                if (cnt >= 0) cnt++;
            end
        end
        if (cnt == 4) complete++;
        chk(drop_count == 16'(total - complete), "rndB_drop", drop_count, total - complete);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tcp_tx_arbiter.md
Name: tcp_tx_arbiter

Overview:
- Shares the single SiTCP TCP transmit byte stream (tcp_tx_wr/tcp_tx_data, flow-controlled by tcp_tx_full) between N_SRC packet-framed byte sources.
- Grants are round-robin at packet granularity. An optional one-byte source-ID header is prepended to each packet.
- Packets in flight when the TCP connection closes are flushed and counted as dropped.
- Sits in the SYSCLK domain between user data producers and the network block's TCP TX port.

Parameters:
- N_SRC, 4, number of requesters; legal range 2..8.
- HDR_EN, 1, 1 = emit header byte 0xA0 | src_id[2:0] before each packet; 0 = no header.

Ports:
- CLK  in  1  system clock (SYSCLK domain, 125 MHz).
- RSTn  in  1  asynchronous active-low reset.
- tcp_open_ack  in  1  TCP connection established.
- tcp_tx_full  in  1  SiTCP TX almost-full.
- tcp_tx_wr  out  1  registered write strobe to SiTCP.
- tcp_tx_data  out  8  registered write byte to SiTCP.
- src_valid  in  N_SRC  per-source byte valid.
- src_data  in  8*N_SRC  per-source byte; source i occupies bits [8i+7:8i].
- src_last  in  N_SRC  marks the final byte of a packet.
- src_ready  out  N_SRC  per-source accept; combinational from state and inputs.
- grant_id  out  3  index of the currently or most recently granted source.
- busy  out  1  high in any state other than IDLE.
- drop_count  out  16  packets truncated by connection loss; saturates at 0xFFFF.

Behaviour:
- Reset (RSTn low, async): state=IDLE, tcp_tx_wr=0, tcp_tx_data=0, src_ready=0, grant_id=0, busy=0, drop_count=0, round-robin pointer such that source 0 has highest priority first.
- A byte is transferred on source i when src_valid[i] & src_ready[i] at a rising edge.
- States: IDLE, HEADER, DATA, FLUSH.
- IDLE:
  - src_ready all 0.
  - If tcp_open_ack & ~tcp_tx_full & |src_valid: select the first valid source searching upward (with wrap) from last grant+1, latch grant_id, go to HEADER if HDR_EN else DATA.
  - Otherwise remain in IDLE. Sources are held, not drained, while the connection is closed.
- HEADER:
  - If ~tcp_open_ack: go to FLUSH.
  - Else if ~tcp_tx_full: next cycle tcp_tx_wr=1, tcp_tx_data=8'hA0|grant_id; go to DATA.
  - Else stall with tcp_tx_wr=0.
- DATA:
  - src_ready[grant_id] = tcp_open_ack & ~tcp_tx_full; all other ready bits 0.
  - On transfer: next cycle tcp_tx_wr=1, tcp_tx_data=byte (1-cycle latency); otherwise tcp_tx_wr=0.
  - Transfer with src_last: go to IDLE. The next arbitration may grant in the cycle after the IDLE entry, giving a minimum 1-cycle gap (2 with header).
  - If tcp_open_ack=0 in DATA, go to FLUSH and increment drop_count (saturating). The same applies in HEADER. Loss of tcp_open_ack takes priority over a simultaneous tcp_tx_full or last-byte event; a byte presented that cycle is not accepted.
- FLUSH:
  - src_ready[grant_id]=1 and tcp_tx_wr=0; the granted source's bytes are discarded.
  - On a transfer with src_last: go to IDLE.
- tcp_tx_full is almost-full. The one registered byte already in flight after full asserts is permitted.
- The round-robin pointer updates only on grant.
- A source that drops src_valid mid-packet simply stalls the arbiter; there is no timeout.
- tcp_tx_data holds its last value when tcp_tx_wr=0.
- Reset mid-packet: return to reset values immediately; the partial packet is not completed and drop_count is cleared.
- Implementation size: 150-250 lines.

Test Plan:
1. HDR_EN=1, open_ack=1, source 0 sends 3 bytes 11,22,33 (last on 33) -> tcp_tx_wr pulses 4 consecutive cycles with A0,11,22,33; busy back to 0 after the last byte.
2. Sources 0, 1 and 3 each hold a 2-byte packet valid continuously -> output order src0, src1, src3, src0; headers A0, A1, A3, A0.
3. tcp_tx_full asserted for 5 cycles during DATA of a 10-byte packet -> src_ready low those cycles, at most 1 write after full rises, all 10 bytes delivered in order with none lost or duplicated.
4. tcp_open_ack drops after byte 4 of an 8-byte packet -> no further tcp_tx_wr; remaining 4 bytes accepted with src_ready=1; drop_count=1; IDLE after last.
5. tcp_open_ack=0 with src_valid=4'b1111 -> src_ready=0, tcp_tx_wr=0 indefinitely. Raising open_ack -> grant goes to source 0 first.
6. RSTn pulsed low mid-packet -> outputs at reset values asynchronously. After release, a new packet from source 2 is emitted cleanly with header A2.
